// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: opcodes, FSM states, data width
// and the magnitude helper used when a signed operand enters the unsigned datapath.
package hilo_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_MADD  = 3'b011,
        OP_MSUB  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_WRITE = 2'b10
    } state_e;

    // 0x80000000 maps to itself, which is the correct magnitude read as unsigned.
    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Iterative unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per
// step; last_o flags the step that completes the product.
module shift_add_core
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_W-1:0]     mcand_i,
    input  logic [DATA_W-1:0]     mplier_i,
    output logic [2*DATA_W-1:0]   product_o,
    output logic                  last_o
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2*DATA_W-1:0] pp [BITS_PER_CYCLE];
    logic [2*DATA_W-1:0] pp_sum;

    // One partial product per multiplier bit retired in this step.
    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            pp_sum = pp_sum + pp[k];
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = {{DATA_W{1'b0}}, mcand_i};
            acc_d    = '0;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            acc_d    = acc_q + pp_sum;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product_o = acc_q;
    assign last_o    = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/hilo_mult_controller.sv
// HI/LO sequencer: issues multiply-class ops to the shift-add core, applies the sign and
// MADD/MSUB accumulation in WRITE, and serves MTHI/MTLO and MFHI/MFLO with stall.
module hilo_mult_controller
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              ReadHiLo,
    input  logic              HiLoSel,
    output logic [DATA_W-1:0] ReadData,
    output logic              Busy,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    op_e                 op_in;
    logic                core_load, core_step, core_last;
    logic [DATA_W-1:0]   mcand_in, mplier_in;
    logic [2*DATA_W-1:0] core_product, signed_product, hilo_cur, hilo_new;

    assign op_in = op_e'(Op);

    // MULTU feeds raw operands; the signed ops feed magnitudes and fix the sign in WRITE.
    assign mcand_in  = (op_in == OP_MULTU) ? RsData : abs32(RsData);
    assign mplier_in = (op_in == OP_MULTU) ? RtData : abs32(RtData);

    shift_add_core #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .clk_i    (Clk),
        .srst_i   (Rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .mcand_i  (mcand_in),
        .mplier_i (mplier_in),
        .product_o(core_product),
        .last_o   (core_last)
    );

    assign signed_product = sign_q ? (~core_product + 1'b1) : core_product;
    assign hilo_cur       = {hi_q, lo_q};

    always_comb begin
        case (op_q)
            OP_MADD: hilo_new = hilo_cur + signed_product;
            OP_MSUB: hilo_new = hilo_cur - signed_product;
            default: hilo_new = signed_product;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_d    = sign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            core_load = 1'b1;
                            op_d      = op_in;
                            sign_d    = (op_in == OP_MULTU) ? 1'b0
                                                            : (RsData[DATA_W-1] ^ RtData[DATA_W-1]);
                            state_d   = S_CALC;
                        end
                        OP_MTHI: hi_d = RsData;
                        OP_MTLO: lo_d = RsData;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                Busy      = 1'b1;
                core_step = 1'b1;
                if (core_last) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                hi_d    = hilo_new[2*DATA_W-1:DATA_W];
                lo_d    = hilo_new[DATA_W-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Stall    = Busy & (Start | ReadHiLo);
    assign ReadData = HiLoSel ? hi_q : lo_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule

// File: tb/tb_hilo_mult_controller.sv
// Drives three controller instances (1, 2 and 4 bits per cycle) and checks timing and
// HI/LO contents against a 64-bit arithmetic reference model.
module tb_hilo_mult_controller;
    import hilo_pkg::*;

    logic        clk;
    logic        rst   [3];
    logic        start [3];
    logic [2:0]  op    [3];
    logic [31:0] rs    [3];
    logic [31:0] rt    [3];
    logic        rd    [3];
    logic        sel   [3];

    wire  [31:0] rdata_w [3];
    wire  [31:0] hi_w    [3];
    wire  [31:0] lo_w    [3];
    wire         busy_w  [3];
    wire         stall_w [3];
    wire         done_w  [3];

    logic [63:0] model [3];
    int vectors;
    int miscompares;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            hilo_mult_controller #(
                .BITS_PER_CYCLE(1 << gi)
            ) u_dut (
                .Clk     (clk),
                .Rst     (rst[gi]),
                .Start   (start[gi]),
                .Op      (op[gi]),
                .RsData  (rs[gi]),
                .RtData  (rt[gi]),
                .ReadHiLo(rd[gi]),
                .HiLoSel (sel[gi]),
                .ReadData(rdata_w[gi]),
                .Busy    (busy_w[gi]),
                .Stall   (stall_w[gi]),
                .Done    (done_w[gi]),
                .Hi      (hi_w[gi]),
                .Lo      (lo_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Multiply-class op: checks Busy/Done/Stall every cycle, then HI/LO after completion.
    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] exp_v;
        int n;
        n = 32 >> d;
        if (o == OP_MULTU) p = {32'b0, a} * {32'b0, b};
        else               p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        case (o)
            OP_MADD: exp_v = model[d] + p;
            OP_MSUB: exp_v = model[d] - p;
            default: exp_v = p;
        endcase
        start[d] = 1'b1; op[d] = o; rs[d] = a; rt[d] = b; #1;
        vectors++;
        if (busy_w[d] !== 1'b0 || stall_w[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL issue_idle d=%0d busy=%b stall=%b expected 0 0", d, busy_w[d], stall_w[d]);
        end
        @(posedge clk); #1;
        start[d] = 1'b0; op[d] = OP_NOP; #1;
        for (int c = 1; c <= n + 2; c++) begin
            vectors++;
            if (busy_w[d] !== ((c <= n + 1) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL busy d=%0d cycle=%0d got=%b", d, c, busy_w[d]);
            end
            vectors++;
            if (done_w[d] !== ((c == n + 1) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL done d=%0d cycle=%0d got=%b", d, c, done_w[d]);
            end
            vectors++;
            if (stall_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_quiet d=%0d cycle=%0d got=%b expected 0", d, c, stall_w[d]);
            end
            if (c <= n + 1) begin
                @(posedge clk); #2;
            end
        end
        vectors++;
        if ({hi_w[d], lo_w[d]} !== exp_v) begin
            miscompares++;
            $display("FAIL result d=%0d op=%0d got=%h_%h expected=%h", d, o, hi_w[d], lo_w[d], exp_v);
        end
        model[d] = exp_v;
        $display("d=%0d op=%0d rs=%h rt=%h -> hi=%h lo=%h", d, o, a, b, hi_w[d], lo_w[d]);
    endtask

    task automatic run_mt(input int d, input logic [2:0] o, input logic [31:0] v);
        start[d] = 1'b1; op[d] = o; rs[d] = v; #1;
        @(posedge clk); #1;
        start[d] = 1'b0; op[d] = OP_NOP; #1;
        if (o == OP_MTHI) model[d][63:32] = v;
        else              model[d][31:0]  = v;
        vectors++;
        if (busy_w[d] !== 1'b0 || {hi_w[d], lo_w[d]} !== model[d]) begin
            miscompares++;
            $display("FAIL move d=%0d busy=%b got=%h_%h expected=%h", d, busy_w[d], hi_w[d], lo_w[d], model[d]);
        end
        sel[d] = 1'b1; #1;
        vectors++;
        if (rdata_w[d] !== model[d][63:32]) begin
            miscompares++;
            $display("FAIL read_hi d=%0d got=%h expected=%h", d, rdata_w[d], model[d][63:32]);
        end
        sel[d] = 1'b0; #1;
        vectors++;
        if (rdata_w[d] !== model[d][31:0]) begin
            miscompares++;
            $display("FAIL read_lo d=%0d got=%h expected=%h", d, rdata_w[d], model[d][31:0]);
        end
        $display("d=%0d op=%0d rs=%h -> hi=%h lo=%h", d, o, v, hi_w[d], lo_w[d]);
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1; start[d] = 1'b1; op[d] = OP_MULT; rs[d] = 32'd5; rt[d] = 32'd5; rd[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0; start[d] = 1'b0; op[d] = OP_NOP; rd[d] = 1'b0; #1;
        model[d] = 64'd0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || stall_w[d] !== 1'b0 ||
                hi_w[d] !== 32'd0 || lo_w[d] !== 32'd0 || rdata_w[d] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset d=%0d busy=%b done=%b stall=%b hi=%h lo=%h rdata=%h expected all 0",
                         d, busy_w[d], done_w[d], stall_w[d], hi_w[d], lo_w[d], rdata_w[d]);
            end
            @(posedge clk); #2;
        end
        $display("d=%0d reset with start -> busy=%b hi=%h lo=%h", d, busy_w[d], hi_w[d], lo_w[d]);
    endtask

    task automatic test_directed(input int d);
        run_op(d, OP_MULT, 32'd7, 32'hFFFF_FFFD);
        vectors++;
        if (hi_w[d] !== 32'hFFFF_FFFF || lo_w[d] !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mult_7_m3 d=%0d got=%h_%h expected=ffffffff_ffffffeb", d, hi_w[d], lo_w[d]);
        end
        run_op(d, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vectors++;
        if (hi_w[d] !== 32'hFFFF_FFFE || lo_w[d] !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL multu_max d=%0d got=%h_%h expected=fffffffe_00000001", d, hi_w[d], lo_w[d]);
        end
        run_op(d, OP_MULT, 32'h8000_0000, 32'h8000_0000);
        vectors++;
        if (hi_w[d] !== 32'h4000_0000 || lo_w[d] !== 32'h0) begin
            miscompares++;
            $display("FAIL mult_min d=%0d got=%h_%h expected=40000000_00000000", d, hi_w[d], lo_w[d]);
        end
        run_mt(d, OP_MTHI, 32'h0);
        run_mt(d, OP_MTLO, 32'hFFFF_FFFF);
        run_op(d, OP_MADD, 32'd1, 32'd1);
        vectors++;
        if (hi_w[d] !== 32'd1 || lo_w[d] !== 32'd0) begin
            miscompares++;
            $display("FAIL madd_carry d=%0d got=%h_%h expected=00000001_00000000", d, hi_w[d], lo_w[d]);
        end
        run_mt(d, OP_MTHI, 32'h0);
        run_mt(d, OP_MTLO, 32'h0);
        run_op(d, OP_MSUB, 32'd2, 32'd3);
        vectors++;
        if (hi_w[d] !== 32'hFFFF_FFFF || lo_w[d] !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL msub_borrow d=%0d got=%h_%h expected=ffffffff_fffffffa", d, hi_w[d], lo_w[d]);
        end
    endtask

    task automatic test_stall_read(input int d);
        int n;
        logic [31:0] old_lo;
        n = 32 >> d;
        old_lo = model[d][31:0];
        rd[d] = 1'b1; sel[d] = 1'b0;
        start[d] = 1'b1; op[d] = OP_MULTU; rs[d] = 32'd3; rt[d] = 32'd5; #1;
        vectors++;
        if (stall_w[d] !== 1'b0 || rdata_w[d] !== old_lo) begin
            miscompares++;
            $display("FAIL read_at_issue d=%0d stall=%b rdata=%h expected 0 %h", d, stall_w[d], rdata_w[d], old_lo);
        end
        @(posedge clk); #1;
        start[d] = 1'b0; op[d] = OP_NOP; #1;
        for (int c = 1; c <= n + 2; c++) begin
            if (c == 3) begin
                start[d] = 1'b1; op[d] = OP_MULT; rs[d] = 32'd2; rt[d] = 32'd2; #1;
            end
            vectors++;
            if (stall_w[d] !== ((c <= n + 1) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL stall_read d=%0d cycle=%0d got=%b", d, c, stall_w[d]);
            end
            if (c == n + 2) begin
                vectors++;
                if (rdata_w[d] !== 32'd15 || busy_w[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_after_write d=%0d rdata=%h busy=%b expected 0000000f 0", d, rdata_w[d], busy_w[d]);
                end
            end else begin
                @(posedge clk); #1;
                start[d] = 1'b0; op[d] = OP_NOP; #1;
            end
        end
        rd[d] = 1'b0;
        model[d] = 64'd15;
        vectors++;
        if ({hi_w[d], lo_w[d]} !== model[d]) begin
            miscompares++;
            $display("FAIL ignored_start d=%0d got=%h_%h expected=%h", d, hi_w[d], lo_w[d], model[d]);
        end
        $display("d=%0d multu 3*5 with held read -> rdata=%h", d, rdata_w[d]);
    endtask

    task automatic test_reset_mid(input int d);
        int n;
        int k;
        n = 32 >> d;
        k = (d == 2) ? n + 1 : 10;
        run_mt(d, OP_MTHI, 32'h1234_5678);
        start[d] = 1'b1; op[d] = OP_MULT; rs[d] = $urandom; rt[d] = $urandom; #1;
        @(posedge clk); #1;
        start[d] = 1'b0; op[d] = OP_NOP;
        for (int c = 1; c < k; c++) begin
            @(posedge clk); #1;
        end
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0; #1;
        model[d] = 64'd0;
        for (int c = 0; c < n + 3; c++) begin
            vectors++;
            if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || hi_w[d] !== 32'd0 || lo_w[d] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_mid d=%0d cycle=%0d busy=%b done=%b hi=%h lo=%h expected all 0",
                         d, c, busy_w[d], done_w[d], hi_w[d], lo_w[d]);
            end
            @(posedge clk); #2;
        end
        $display("d=%0d reset in cycle %0d -> busy=%b hi=%h lo=%h", d, k, busy_w[d], hi_w[d], lo_w[d]);
        run_op(d, OP_MULT, 32'd6, 32'd7);
        vectors++;
        if (lo_w[d] !== 32'd42) begin
            miscompares++;
            $display("FAIL mult_after_reset d=%0d lo=%h expected=0000002a", d, lo_w[d]);
        end
    endtask

    task automatic test_nop(input int d);
        logic [2:0] nops [2];
        nops[0] = OP_NOP;
        nops[1] = 3'b111;
        run_mt(d, OP_MTLO, $urandom);
        for (int i = 0; i < 2; i++) begin
            start[d] = 1'b1; op[d] = nops[i]; rs[d] = $urandom; rt[d] = $urandom; #1;
            @(posedge clk); #1;
            start[d] = 1'b0; op[d] = OP_NOP; #1;
            vectors++;
            if (busy_w[d] !== 1'b0 || {hi_w[d], lo_w[d]} !== model[d]) begin
                miscompares++;
                $display("FAIL nop d=%0d op=%0d busy=%b got=%h_%h expected=%h",
                         d, nops[i], busy_w[d], hi_w[d], lo_w[d], model[d]);
            end
            $display("d=%0d op=%0d (no effect) -> hi=%h lo=%h", d, nops[i], hi_w[d], lo_w[d]);
        end
    endtask

    task automatic test_random(input int d);
        logic [2:0] o;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(1, 6));
            if (o == OP_MTHI || o == OP_MTLO) run_mt(d, o, pick_operand());
            else                              run_op(d, o, pick_operand(), pick_operand());
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [2:0] seq [4];
        seq[0] = OP_MULT; seq[1] = OP_MADD; seq[2] = OP_MSUB; seq[3] = OP_MULTU;
        for (int i = 0; i < 4; i++) begin
            run_op(d, seq[i], $urandom, $urandom);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; op[d] = OP_NOP;
            rs[d] = 32'd0; rt[d] = 32'd0; rd[d] = 1'b0; sel[d] = 1'b0;
            model[d] = 64'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            test_reset(d);
            test_directed(d);
            test_stall_read(d);
            test_reset_mid(d);
            test_nop(d);
            test_back_to_back(d);
            test_random(d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_mult_controller.md
# hilo_mult_controller

Multi-cycle sequencer for the HI/LO register pair in the Memory stage. It accepts multiply-class instructions from the pipeline and runs an iterative shift-add multiplier over several cycles. It then writes or accumulates the 64-bit result into HI/LO, and serves MFHI/MFLO reads, asserting Stall while a result is pending. It replaces the single-cycle multiply path feeding the HI/LO write mux.

## Interface
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4; N = 32/BITS_PER_CYCLE
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Start  in  1  issue the operation on Op this cycle
- Op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 MADD, 100 MSUB, 101 MTHI, 110 MTLO
- RsData  in  32  multiplicand / MTHI/MTLO source
- RtData  in  32  multiplier
- ReadHiLo  in  1  MFHI/MFLO request
- HiLoSel  in  1  1 = HI, 0 = LO for ReadData
- ReadData  out  32  selected HI or LO (combinational from registers)
- Busy  out  1  operation in CALC or WRITE
- Stall  out  1  combinational; = Busy & (Start | ReadHiLo)
- Done  out  1  one-cycle pulse in the WRITE cycle
- Hi, Lo  out  32  architectural HI/LO registers

## Operation
- States: IDLE, CALC, WRITE.
- IDLE, Start with MULT/MULTU/MADD/MSUB:
  - latch |Rs|, |Rt| (raw for MULTU), the product sign Rs[31]^Rt[31] (0 for MULTU), and Op
  - clear the 64-bit accumulator and counter; go to CALC
- IDLE, Start with MTHI/MTLO: Hi (or Lo) <= RsData at the next edge; stay in IDLE; Busy stays 0.
- IDLE, Start with NOP or an undefined Op (111): no effect.
- CALC: each cycle add BITS_PER_CYCLE partial products and shift. After N cycles go to WRITE.
- WRITE: negate the product if the sign bit is set, then:
  - MULT/MULTU: {Hi,Lo} <= P
  - MADD: {Hi,Lo} <= {Hi,Lo} + P
  - MSUB: {Hi,Lo} <= {Hi,Lo} - P
  - Arithmetic is 64-bit modulo 2^64, with no overflow flag. Return to IDLE.
- MULT and MADD/MSUB are signed. The magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.
- Start while Busy is ignored. Stall stays high, so the pipeline holds the instruction and re-presents it.
- A ReadHiLo while Busy is stalled until the cycle after WRITE.

## Timing
- Reset values: state IDLE; Hi, Lo, accumulator and counter 0; Busy, Done, Stall 0; ReadData 0.
- Rst has priority over everything, including Start in the same cycle and any operation in progress. A reset mid-CALC or mid-WRITE discards the operation and leaves HI/LO at 0.
- Start at edge 0:
  - Busy high in cycles 1..N+1
  - Done high in cycle N+1 (the WRITE cycle)
  - new Hi/Lo visible from cycle N+2
  - latency N+1 cycles; back-to-back issue every N+2 cycles
- MTHI/MTLO: updated value visible the cycle after Start.
- ReadHiLo in the WRITE cycle stalls (Busy = 1). In the next cycle it reads the new value with no stall.
- Start and ReadHiLo in the same IDLE cycle: the read returns the old HI/LO. The operation proceeds.

## Structure
- Shared package `hilo_pkg`:
  - Op encodings (OP_NOP..OP_MTLO)
  - state encoding (S_IDLE, S_CALC, S_WRITE)
  - the 32-bit data width constant
- One sub-module, `shift_add_core`:
  - holds the multiplicand, multiplier shift register, 64-bit partial accumulator and iteration counter
  - inputs: load, step
  - outputs: product, last
- `hilo_mult_controller` holds the FSM, sign handling, the final accumulate/subtract, HI/LO registers and the read mux.

## Test plan
- MULT Rs=7, Rt=0xFFFFFFFD (-3), BITS_PER_CYCLE=1:
  - Busy for 33 cycles, Done in cycle 33
  - then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB
- MULTU 0xFFFFFFFF*0xFFFFFFFF gives Hi=0xFFFFFFFE, Lo=0x00000001. MULT 0x80000000*0x80000000 gives Hi=0x40000000, Lo=0.
- Accumulate, starting from Hi=0, Lo=0 loaded via MTHI/MTLO:
  - MTLO 0xFFFFFFFF, then MADD 1*1: Hi=1, Lo=0
  - from Hi=0, Lo=0, MSUB 2*3: Hi=0xFFFFFFFF, Lo=0xFFFFFFFA
- MULTU 3*5 in flight with ReadHiLo=1, HiLoSel=0 held:
  - Stall high through the WRITE cycle
  - the following cycle Stall=0, ReadData=15
  - a second Start during Busy has no effect
- Rst pulsed in CALC cycle 10:
  - the next cycle shows Busy=0, Hi=Lo=0, Done never pulses
  - a subsequent MULT 6*7 gives Lo=42
- Repeat the first three scenarios with BITS_PER_CYCLE=2 and 4: latency 17 and 9 cycles, identical results.
